mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Load/store unit on the consumer side of the ALU-control decode. It takes the `mem` size code, the ALU-computed address and the store operand. It performs one access on a single-outstanding request/acknowledge data-memory bus: byte-lane steering, store-data replication, and load sign/zero extension. Misaligned or illegal accesses are trapped, and a stalled bus is cut off by a timeout.

Parameters:
TIMEOUT_CYCLES, 16, cycles in REQ without bus_ack before the access is aborted (2..255)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin an access; sampled only in IDLE
is_store  input  1  1 = store, 0 = load; sampled with start
mem_code  input  3  001 byte signed, 010 half signed, 011 word, 101 byte unsigned, 110 half unsigned
addr  input  32  byte address from ALU; sampled with start
store_data  input  32  store operand (rs2); sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at end of every accepted access (success or error)
misalign  output  1  valid with done: illegal code or misaligned address
timeout  output  1  valid with done: bus did not acknowledge in time
load_data  output  32  extended load result; valid from done, held until next successful load
bus_req  output  1  bus request
bus_we  output  1  bus write enable
bus_addr  output  32  word-aligned address: {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  bus completion; rdata valid in the same cycle
bus_rdata  input  32  bus read data

Behaviour:
- Single clock `clk`. Reset is synchronous and active-low on `reset_n`.
- Reset: state=IDLE; busy, done, misalign, timeout, bus_req, bus_we all 0; bus_addr, bus_be, bus_wdata, load_data all 0; timeout counter 0.
- Reset asserted mid-access drops bus_req at that edge. No done pulse is produced.
- States: IDLE, REQ, RESP, ERR.
- IDLE + start=1: latch is_store, mem_code, addr, store_data. Then check legality:
  - Illegal if mem_code is 000, 100 or 111.
  - Illegal if is_store and mem_code is 101 or 110.
  - Illegal if half with addr[0]=1.
  - Illegal if word with addr[1:0]!=0.
  - Illegal → ERR. Legal → REQ.
- ERR, one cycle: done=1, misalign=1. No bus activity. Then IDLE.
- REQ:
  - bus_req=1, bus_we=is_store. bus_addr, bus_be and bus_wdata are driven from latched values and stay stable until ack.
  - Counter counts cycles in REQ.
  - bus_ack=1 → capture and extend bus_rdata (loads only) → RESP. bus_req goes low the next cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without ack → RESP with timeout=1. load_data is unchanged.
- RESP, one cycle: done=1, timeout per the abort flag, misalign=0. Then IDLE.
- Minimum latency: start in cycle N, bus_req high in N+1, ack in N+1, done in N+2.
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Word: 1111.
- Write data: byte → {4{sd[7:0]}}; half → {2{sd[15:0]}}; word → sd.
- Load extraction:
  - Lane is rdata[8*addr[1:0] +: 8] for bytes and rdata[16*addr[1] +: 16] for halves.
  - Codes 001/010 sign-extend to 32 bits; 101/110 zero-extend.
- start while busy=1 is ignored. No queueing.
- bus_ack outside REQ is ignored.
- Stores never modify load_data.
- done and the start of a new access never coincide: the earliest next start is accepted in the cycle after done.

Test Plan:
- Load byte signed: addr=0x1003, code 001, bus_rdata=0x80FF_1234, ack in first REQ cycle → bus_be=1000, bus_addr=0x1000, done in cycle N+2, load_data=0xFFFF_FF80.
- Load half unsigned: addr=0x2002, code 110, rdata=0x9ABC_0000 → be=1100, load_data=0x0000_9ABC. Same with code 010 → 0xFFFF_9ABC.
- Store byte: addr=0x11, code 001, store_data=0xDEAD_BEA5, ack after 3 wait cycles → bus_we=1, be=0010, wdata=0xA5A5_A5A5. bus signals stable all 4 REQ cycles. load_data unchanged.
- Misalign:
  - Word store at addr=0x6 → done=1, misalign=1 at N+1. bus_req never rises.
  - Store with code 101 → same response.
- Timeout: TIMEOUT_CYCLES=4, load with no ack → bus_req high exactly 4 cycles, then done=1, timeout=1. start pulses during busy are ignored.
- Reset mid-REQ: reset_n=0 for one cycle during REQ → next cycle bus_req=0, busy=0, no done pulse. A following load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: one access per start on a single-outstanding req/ack bus,
// with byte-lane steering, store replication, load extension, misalign trap and timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  mem_code,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        timeout,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic        r_is_store;
  logic [2:0]  r_code;
  logic [1:0]  r_lane;
  logic [7:0]  r_cnt;
  logic        r_abort;
  logic [31:0] r_bus_addr, r_wdata, r_load;
  logic [3:0]  r_be;

  logic        w_illegal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // mem_code[1:0] is the size (01 byte, 10 half, 11 word); mem_code[2] marks unsigned.
  always_comb begin
    w_illegal = 1'b0;
    if (mem_code[1:0] == 2'b00 || mem_code == 3'b111)         w_illegal = 1'b1;
    if (is_store && mem_code[2])                               w_illegal = 1'b1;
    if (mem_code[1:0] == 2'b10 && addr[0])                     w_illegal = 1'b1;
    if (mem_code[1:0] == 2'b11 && addr[1:0] != 2'b00)          w_illegal = 1'b1;
  end

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = store_data;
    case (mem_code[1:0])
      2'b01: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b10: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      2'b11: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_shift = bus_rdata >> {r_lane, 3'b000};
  assign w_half  = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_ext = bus_rdata;
    case (r_code[1:0])
      2'b01:   w_ext = r_code[2] ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b10:   w_ext = r_code[2] ? {16'd0, w_half}       : {{16{w_half[15]}}, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_illegal ? S_ERR : S_REQ;
      S_REQ:   if (bus_ack || r_cnt == LP_LAST) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_is_store <= 1'b0;
      r_code     <= 3'b000;
      r_lane     <= 2'b00;
      r_cnt      <= 8'd0;
      r_abort    <= 1'b0;
      r_bus_addr <= 32'd0;
      r_be       <= 4'b0000;
      r_wdata    <= 32'd0;
      r_load     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_is_store <= is_store;
          r_code     <= mem_code;
          r_lane     <= addr[1:0];
          r_bus_addr <= {addr[31:2], 2'b00};
          r_be       <= w_be;
          r_wdata    <= w_wdata;
          r_cnt      <= 8'd0;
          r_abort    <= 1'b0;
        end
        S_REQ: begin
          if (bus_ack) begin
            if (!r_is_store) r_load <= w_ext;
          end else if (r_cnt == LP_LAST) begin
            r_abort <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_RESP) || (r_state == S_ERR);
  assign misalign  = (r_state == S_ERR);
  assign timeout   = (r_state == S_RESP) && r_abort;
  assign bus_req   = (r_state == S_REQ);
  assign bus_we    = (r_state == S_REQ) && r_is_store;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;
  assign load_data = r_load;

endmodule
